// File: rtl/mul_acc_drain_pkg.sv
// mul_acc_drain shared definitions.
// State encoding and widths shared with the multiplier instance.
package mul_acc_drain_pkg;

  localparam int RES_WIDTH_DEF = 64;
  localparam int LEN_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_acc_drain_acc_add.sv
// Registered accumulator adder with clear, enable and sticky carry.
// The addend is zero-extended to the accumulator width.
module mul_acc_drain_acc_add #(
  parameter int W    = 72,
  parameter int IN_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic [IN_W-1:0] addend,
  output logic [W-1:0]    sum,
  output logic            ovf
);

  logic [W:0] nxt;

  // One-bit-wider add so the carry out of W is visible.
  always_comb begin
    nxt = {1'b0, sum} + {{(W + 1 - IN_W){1'b0}}, addend};
  end

  // Sum register; clear wins over enable, carry is sticky until clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      sum <= nxt[W-1:0];
      ovf <= ovf | nxt[W];
    end
  end

endmodule

// File: rtl/mul_acc_drain.sv
// Drains N products from the multiplier read port and sums them.
// Result is offered on a valid/ready port until accepted.
module mul_acc_drain
  import mul_acc_drain_pkg::*;
#(
  parameter int RES_WIDTH = RES_WIDTH_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF,
  parameter int ACC_WIDTH = RES_WIDTH + LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 mul_rd_ready,
  input  logic                 mul_rd_val,
  input  logic [RES_WIDTH-1:0] mul_rd_data,
  output logic                 mul_rd_en,
  output logic [ACC_WIDTH-1:0] acc_data,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic                 busy,
  output logic                 acc_ovf,
  output logic                 proto_err
);

  state_t               state;
  state_t               state_nxt;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt;
  logic                 acc_clr;
  logic                 acc_en;
  logic                 last;

  assign last      = (cnt == len_q - LEN_WIDTH'(1));
  assign busy      = (state != IDLE);
  assign acc_valid = (state == DONE);

  // Next state, read strobe and accumulator controls.
  always_comb begin
    state_nxt = state;
    mul_rd_en = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_clr   = 1'b1;
          state_nxt = (cfg_len == '0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (mul_rd_ready) begin
          mul_rd_en = 1'b1;
          state_nxt = CAPT;
        end
      end
      CAPT: begin
        if (mul_rd_val) begin
          acc_en    = 1'b1;
          state_nxt = last ? DONE : WAIT;
        end else begin
          state_nxt = WAIT;
        end
      end
      DONE: begin
        if (acc_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, job length, product count and sticky protocol flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= '0;
      cnt       <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        len_q     <= cfg_len;
        cnt       <= '0;
        proto_err <= 1'b0;
      end
      if (state == CAPT) begin
        if (mul_rd_val) cnt <= cnt + 1'b1;
        else proto_err <= 1'b1;
      end
    end
  end

  mul_acc_drain_acc_add #(
    .W    (ACC_WIDTH),
    .IN_W (RES_WIDTH)
  ) u_acc (
    .clk    (clk),
    .reset  (reset),
    .clr    (acc_clr),
    .en     (acc_en),
    .addend (mul_rd_data),
    .sum    (acc_data),
    .ovf    (acc_ovf)
  );

endmodule

// File: tb/tb_mul_acc_drain.sv
// Scoreboard bench for mul_acc_drain: wide and ACC=RES instances in lockstep.
// Expected sums come from plain arithmetic over each job's product list.
module tb_mul_acc_drain;

  localparam int RW = 64;
  localparam int LW = 8;
  localparam int AW = 72;
  localparam int NW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          mul_rd_ready = 1'b0;
  logic          mul_rd_val = 1'b0;
  logic [RW-1:0] mul_rd_data = '0;
  logic          acc_ready = 1'b0;

  logic          en_w, valid_w, busy_w, ovf_w, perr_w;
  logic [AW-1:0] data_w;
  logic          en_n, valid_n, busy_n, ovf_n, perr_n;
  logic [NW-1:0] data_n;

  always #5 clk = ~clk;

  mul_acc_drain dut (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
    .mul_rd_ready(mul_rd_ready), .mul_rd_val(mul_rd_val),
    .mul_rd_data(mul_rd_data), .mul_rd_en(en_w), .acc_data(data_w),
    .acc_valid(valid_w), .acc_ready(acc_ready), .busy(busy_w),
    .acc_ovf(ovf_w), .proto_err(perr_w)
  );

  mul_acc_drain #(.ACC_WIDTH(NW)) dut_n (
    .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
    .mul_rd_ready(mul_rd_ready), .mul_rd_val(mul_rd_val),
    .mul_rd_data(mul_rd_data), .mul_rd_en(en_n), .acc_data(data_n),
    .acc_valid(valid_n), .acc_ready(acc_ready), .busy(busy_n),
    .acc_ovf(ovf_n), .proto_err(perr_n)
  );

  typedef struct {
    logic [AW-1:0] wide;
    logic          ovf_n;
    logic          perr;
  } exp_t;

  exp_t          exp_q[$];
  logic [RW-1:0] prod_q[$];
  logic [RW-1:0] job_prods[$];

  int checks = 0;
  int failures = 0;
  int en_pulses = 0;
  int r_gap = 0;
  int r_gap_cnt = 0;
  bit r_drop = 1'b0;
  bit r_pending = 1'b0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Multiplier read-port model: val+data the cycle after rd_en,
  // then rd_ready low for r_gap cycles before the next product.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mul_rd_val   = 1'b0;
        mul_rd_ready = 1'b0;
        r_pending    = 1'b0;
        r_gap_cnt    = 0;
      end else if (r_pending) begin
        r_pending    = 1'b0;
        mul_rd_ready = 1'b0;
        r_gap_cnt    = r_gap;
        if (r_drop || prod_q.size() == 0) begin
          r_drop      = 1'b0;
          mul_rd_val  = 1'b0;
          mul_rd_data = {$urandom, $urandom};
        end else begin
          mul_rd_val  = 1'b1;
          mul_rd_data = prod_q.pop_front();
        end
      end else begin
        mul_rd_val  = 1'b0;
        mul_rd_data = {$urandom, $urandom};
        if (r_gap_cnt > 0) r_gap_cnt--;
        mul_rd_ready = (r_gap_cnt == 0) && (prod_q.size() > 0);
      end
      #1;
      if (en_w) begin
        en_pulses++;
        r_pending = 1'b1;
        chk("en_needs_ready", mul_rd_ready, 1);
        chk("en_lockstep", en_n, 1);
      end
    end
  end

  // Monitor: pops an expected result on each accepted output.
  initial begin
    logic [AW-1:0] last;
    bit            last_v;
    exp_t          e;
    last_v = 1'b0;
    last   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (valid_w && last_v) chk("hold_stable", data_w, last);
      chk("valid_lockstep", valid_n, valid_w);
      last_v = valid_w;
      last   = data_w;
      if (valid_w && acc_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got %0h required none", data_w);
        end else begin
          e = exp_q.pop_front();
          chk("acc_data", data_w, e.wide);
          chk("acc_data_n", data_n, e.wide[NW-1:0]);
          chk("acc_ovf", ovf_w, 0);
          chk("acc_ovf_n", ovf_n, e.ovf_n);
          chk("proto_err", perr_w, e.perr);
          chk("proto_err_n", perr_n, e.perr);
        end
      end
    end
  end

  task automatic run_job(input int len, input int gap, input int hold,
                         input bit drop, input bit mid_start);
    exp_t          e;
    logic [AW-1:0] s;
    int            budget;
    int            en0;
    s = '0;
    @(negedge clk);
    r_gap  = gap;
    r_drop = drop;
    foreach (job_prods[i]) begin
      s = s + AW'(job_prods[i]);
      prod_q.push_back(job_prods[i]);
    end
    e.wide  = s;
    e.ovf_n = |s[AW-1:NW];
    e.perr  = drop;
    @(negedge clk);
    en0     = en_pulses;
    start   = 1'b1;
    cfg_len = LW'(len);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (len == 0) chk("empty_latency", valid_w, 1);
    budget = 0;
    while (!valid_w && budget < 5000) begin
      start = mid_start && budget == 1;
      if (start) cfg_len = LW'(5);
      @(negedge clk);
      budget++;
    end
    start = 1'b0;
    if (!valid_w) begin
      checks++;
      failures++;
      $display("FAIL job_timeout: got no acc_valid required acc_valid");
      void'(exp_q.pop_back());
      return;
    end
    repeat (hold) @(negedge clk);
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    chk("valid_drop", valid_w, 0);
    chk("en_count", en_pulses - en0, len + int'(drop));
  endtask

  initial begin
    int budget;
    int en0;
    int len;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_w", {busy_w, valid_w, en_w, ovf_w, perr_w, data_w}, 0);
    chk("reset_n", {busy_n, valid_n, en_n, ovf_n, perr_n, data_n}, 0);
    reset = 1'b0;

    job_prods = '{64'd10, 64'd20, 64'd30};
    run_job(3, 0, 0, 1'b0, 1'b0);

    job_prods = '{};
    run_job(0, 0, 0, 1'b0, 1'b0);

    job_prods = '{{$urandom, $urandom}, {$urandom, $urandom}};
    run_job(2, 5, 4, 1'b0, 1'b0);

    job_prods = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
    run_job(2, 0, 1, 1'b0, 1'b0);

    job_prods = '{64'd7};
    run_job(1, 1, 0, 1'b1, 1'b1);

    @(negedge clk);
    prod_q = '{64'd1, 64'd2, 64'd3, 64'd4};
    r_gap  = 1;
    @(negedge clk);
    en0     = en_pulses;
    start   = 1'b1;
    cfg_len = LW'(4);
    @(negedge clk);
    start = 1'b0;
    #3;
    budget = 0;
    while (!(r_pending && en_pulses >= en0 + 2) && budget < 200) begin
      @(negedge clk);
      #3;
      budget++;
    end
    chk("reach_second_capt", r_pending, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_w", {busy_w, valid_w, en_w, ovf_w, perr_w, data_w}, 0);
    chk("reset_mid_n", {busy_n, valid_n, en_n, ovf_n, perr_n, data_n}, 0);
    reset = 1'b0;
    #3;
    prod_q.delete();
    r_pending = 1'b0;
    r_gap     = 0;
    r_gap_cnt = 0;
    r_drop    = 1'b0;

    job_prods = '{64'd5};
    run_job(1, 0, 0, 1'b0, 1'b0);

    job_prods = '{};
    for (int i = 0; i < 255; i++) job_prods.push_back('1);
    run_job(255, 0, 0, 1'b0, 1'b0);

    for (int j = 0; j < 20; j++) begin
      len = $urandom_range(0, 6);
      job_prods = '{};
      for (int i = 0; i < len; i++) begin
        job_prods.push_back({$urandom, $urandom});
      end
      run_job(len, $urandom_range(0, 3), $urandom_range(0, 3),
              (len > 0) && ($urandom_range(0, 3) == 0), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_acc_drain.md
Name: mul_acc_drain

Overview:
- Downstream consumer stage for the multi-cycle unsigned multiplier.
- Drains a programmed number of products through the multiplier's read handshake (rd_en / rd_ready / rd_val / rd_data) and sums them into a wide accumulator.
- Presents the final sum on a valid/ready output port.
- Turns the multiplier into a sequential dot-product / MAC back end; the upstream issuer feeds operands independently.

Parameters:
- RES_WIDTH, 64, width of the multiplier product bus.
- LEN_WIDTH, 8, width of the programmed product count.
- ACC_WIDTH, RES_WIDTH + LEN_WIDTH, accumulator width; the default cannot overflow for any legal count.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a drain/accumulate job; sampled only in IDLE.
- cfg_len  in  LEN_WIDTH  number of products to accumulate, latched with start.
- mul_rd_ready  in  1  multiplier has a finished product.
- mul_rd_val  in  1  multiplier read-data-valid, asserted the cycle after mul_rd_en.
- mul_rd_data  in  RES_WIDTH  multiplier product.
- mul_rd_en  out  1  read strobe to multiplier.
- acc_data  out  ACC_WIDTH  accumulated sum.
- acc_valid  out  1  acc_data holds a completed job result.
- acc_ready  in  1  downstream accepts the result.
- busy  out  1  high in every state except IDLE.
- acc_ovf  out  1  sticky: carry out of ACC_WIDTH during the job.
- proto_err  out  1  sticky: mul_rd_val low in CAPT.

Behaviour:
- Reset values: mul_rd_en=0, acc_valid=0, busy=0, acc_ovf=0, proto_err=0, acc_data=0, cnt=0, len_q=0; state=IDLE.
- Reset mid-job aborts it immediately. Any in-flight product is discarded; it is not re-requested.
- States: IDLE, WAIT, CAPT, DONE.
- IDLE:
  - On start, latch len_q=cfg_len, clear acc_data, acc_ovf and proto_err, set cnt=0.
  - If cfg_len==0, go to DONE (result 0); otherwise go to WAIT.
- WAIT:
  - mul_rd_en = (state==WAIT) & mul_rd_ready. It is combinational, a single-cycle pulse per product.
  - When asserted, go to CAPT. Otherwise stay.
- CAPT:
  - If mul_rd_val=1: acc_data <= acc_data + zero-extended mul_rd_data (modulo 2^ACC_WIDTH). acc_ovf |= carry out. cnt <= cnt+1.
  - Then go to DONE if cnt==len_q-1, else to WAIT.
  - If mul_rd_val=0: set proto_err, do not accumulate, leave cnt unchanged, return to WAIT.
  - mul_rd_en is 0 in CAPT, so no back-to-back strobe while the multiplier's rd_ready is still falling.
- DONE:
  - acc_valid=1, and acc_data is held stable.
  - On acc_valid & acc_ready, go to IDLE and drop acc_valid next cycle. acc_data keeps its value until the next start.
- start is ignored outside IDLE; no queueing.
- Latency: each product costs 2 cycles minimum (WAIT with mul_rd_ready high, then CAPT). acc_valid rises the cycle after the last CAPT. Minimum job of N products with mul_rd_ready permanently high: 2N+1 cycles from start to acc_valid.
- Widths: len_q and cnt are LEN_WIDTH bits. cfg_len = 2^LEN_WIDTH-1 is the maximum job; cnt never wraps.
- mul_rd_data is sampled only in CAPT; its value in any other state is don't-care.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, WAIT=2'd1, CAPT=2'd2, DONE=2'd3;
  - the default RES_WIDTH/LEN_WIDTH values shared with the multiplier instance.
- One sub-module is natural: acc_add, a registered ACC_WIDTH adder with enable, clear and carry-out. The FSM stays in the top.

Test Plan:
- Basic job:
  - Stimulus: start with cfg_len=3. Model returns products 10, 20, 30, rd_ready high one cycle after each rd_en.
  - Required: exactly 3 mul_rd_en pulses, then acc_valid=1 with acc_data=60, acc_ovf=0, proto_err=0.
- Empty job:
  - Stimulus: start with cfg_len=0.
  - Required: no mul_rd_en. acc_valid rises 1 cycle after start with acc_data=0. It drops 1 cycle after acc_ready.
- Backpressure and stalls:
  - Stimulus: cfg_len=2, mul_rd_ready delayed 5 cycles per product. Hold acc_ready=0 for 4 cycles in DONE.
  - Required: mul_rd_en never asserts while rd_ready is low. acc_data is stable and acc_valid is held until acc_ready.
- Overflow:
  - Stimulus: ACC_WIDTH=RES_WIDTH override, cfg_len=2, products 2^64-1 and 2.
  - Required: acc_data=1, acc_ovf=1.
- Protocol error and ignored start:
  - Stimulus: mul_rd_val held 0 on the first CAPT, then 1 with product 7 (cfg_len=1). Pulse start mid-job.
  - Required: proto_err=1, acc_data=7, the mid-job start has no effect, and mul_rd_en pulses twice.
- Reset mid-job:
  - Stimulus: assert reset in CAPT of a cfg_len=4 job.
  - Required: next cycle state is IDLE and all outputs are 0. A fresh job with cfg_len=1 and product 5 gives acc_data=5.
